// File: rtl/operand_collector.sv
// ---------------------------------------------------------------------------
// operand_collector
//
// Purpose:
//   Collects the source operands for one instruction at a time. Each operand
//   is resolved when the request is accepted: the register-file value if it
//   has no producer, else a matching bypass broadcast, else the ROB-held
//   result. Operands that cannot be resolved yet are tracked as pending and
//   picked up later from the bypass buses. Once every operand is present the
//   instruction is offered downstream with a valid/ready handshake.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   flush             synchronous flush; drops the held instruction
//   in_valid/in_ready request handshake
//   rf_data           register-file values, operand i in slice i
//   rob_tag/_valid    producer ROB entry per operand
//   rob_data/_valid   ROB-held results per operand
//   byp_data/tag/en   bypass buses, channel 0 has highest priority
//   out_valid/ready   issue handshake
//   out_data          collected operands, operand i in slice i
//   busy              high while waiting on bypass results
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no instruction held, ready for a request
//   WAIT    | instruction held, at least one operand still pending
//   READY   | all operands present, offering out_data downstream
// ---------------------------------------------------------------------------
module operand_collector #(
    parameter int WORD_SIZE       = 32,
    parameter int ROB_ENTRY_WIDTH = 3,
    parameter int NUM_SRC         = 2,
    parameter int NUM_BYPASS      = 6
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_SRC*WORD_SIZE-1:0]          rf_data,
    input  logic [NUM_SRC*ROB_ENTRY_WIDTH-1:0]    rob_tag,
    input  logic [NUM_SRC-1:0]                    rob_tag_valid,
    input  logic [NUM_SRC*WORD_SIZE-1:0]          rob_data,
    input  logic [NUM_SRC-1:0]                    rob_data_valid,
    input  logic [NUM_BYPASS*WORD_SIZE-1:0]       byp_data,
    input  logic [NUM_BYPASS*ROB_ENTRY_WIDTH-1:0] byp_tag,
    input  logic [NUM_BYPASS-1:0]                 byp_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_SRC*WORD_SIZE-1:0]          out_data,
    output logic                                  busy
);

    localparam int W  = WORD_SIZE;
    localparam int TW = ROB_ENTRY_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next;

    logic [NUM_SRC*W-1:0]      r_data;
    logic [NUM_SRC-1:0]        r_pend;
    logic [NUM_SRC*TW-1:0]     r_tag;

    logic                      w_accept;

    // Bypass lookups: one against the incoming tags (acceptance), one against
    // the registered tags (snooping while in WAIT).
    logic [NUM_SRC-1:0]        w_abyp_hit;
    logic [NUM_SRC*W-1:0]      w_abyp_data;
    logic [NUM_SRC-1:0]        w_snp_hit;
    logic [NUM_SRC*W-1:0]      w_snp_data;
    logic [NUM_SRC-1:0]        w_cap;

    logic [NUM_SRC*W-1:0]      w_acc_data;
    logic [NUM_SRC-1:0]        w_acc_pend;

    // Channels are scanned from highest index down so the lowest-index
    // matching channel is the last to write and therefore wins.
    always_comb begin
        w_abyp_hit  = '0;
        w_abyp_data = '0;
        w_snp_hit   = '0;
        w_snp_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = NUM_BYPASS - 1; j >= 0; j--) begin
                if (byp_en[j] && (byp_tag[j*TW +: TW] == rob_tag[i*TW +: TW])) begin
                    w_abyp_hit[i]         = 1'b1;
                    w_abyp_data[i*W +: W] = byp_data[j*W +: W];
                end
                if (byp_en[j] && (byp_tag[j*TW +: TW] == r_tag[i*TW +: TW])) begin
                    w_snp_hit[i]         = 1'b1;
                    w_snp_data[i*W +: W] = byp_data[j*W +: W];
                end
            end
        end
    end

    always_comb begin
        w_acc_data = '0;
        w_acc_pend = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!rob_tag_valid[i]) begin
                w_acc_data[i*W +: W] = rf_data[i*W +: W];
            end else if (w_abyp_hit[i]) begin
                w_acc_data[i*W +: W] = w_abyp_data[i*W +: W];
            end else if (rob_data_valid[i]) begin
                w_acc_data[i*W +: W] = rob_data[i*W +: W];
            end else begin
                w_acc_pend[i] = 1'b1;
            end
        end
    end

    assign w_cap    = r_pend & w_snp_hit;
    assign w_accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (|w_acc_pend) ? ST_WAIT : ST_READY;
                end
            end
            ST_WAIT: begin
                // Operands captured this cycle count toward completion.
                if ((r_pend & ~w_snp_hit) == '0) begin
                    w_next = ST_READY;
                end
            end
            ST_READY: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_next = (|w_acc_pend) ? ST_WAIT : ST_READY;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (flush) begin
            w_next = ST_IDLE;
        end
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        if (!reset && !flush) begin
            in_ready = (r_state == ST_IDLE) || ((r_state == ST_READY) && out_ready);
        end
        out_valid = (r_state == ST_READY);
        busy      = (r_state == ST_WAIT);
    end

    assign out_data = r_data;

    // Operand storage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_pend <= '0;
            r_tag  <= '0;
        end else if (flush) begin
            r_pend <= '0;
        end else if (w_accept) begin
            r_data <= w_acc_data;
            r_pend <= w_acc_pend;
            r_tag  <= rob_tag;
        end else if (r_state == ST_WAIT) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_cap[i]) begin
                    r_data[i*W +: W] <= w_snp_data[i*W +: W];
                end
            end
            r_pend <= r_pend & ~w_cap;
        end
    end

endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, meaning operand data width.
REQ-002 SHALL have parameter ROB_ENTRY_WIDTH, default 3, meaning ROB tag width.
REQ-003 SHALL have parameter NUM_SRC, default 2, meaning number of source operands per instruction.
REQ-004 SHALL have parameter NUM_BYPASS, default 6, meaning number of bypass channels; index 0 has highest priority.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port flush, input, 1, synchronous pipeline flush.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the request handshake.
REQ-009 SHALL have port rf_data, input, NUM_SRC*WORD_SIZE, register-file values; operand i is in slice i.
REQ-010 SHALL have ports rob_tag (input, NUM_SRC*ROB_ENTRY_WIDTH) and rob_tag_valid (input, NUM_SRC), giving the producer ROB entry per operand.
REQ-011 SHALL have ports rob_data (input, NUM_SRC*WORD_SIZE) and rob_data_valid (input, NUM_SRC), giving ROB-held results.
REQ-012 SHALL have ports byp_data (input, NUM_BYPASS*WORD_SIZE), byp_tag (input, NUM_BYPASS*ROB_ENTRY_WIDTH) and byp_en (input, NUM_BYPASS), the bypass buses.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, NUM_SRC*WORD_SIZE), the issue handshake.
REQ-014 SHALL have port busy, output, 1, high while in state WAIT.

Function
REQ-015 SHALL implement states IDLE, WAIT and READY.
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==READY && out_ready), with flush and reset excluded.
REQ-017 SHALL accept a request when in_valid && in_ready, and only then.
REQ-018 SHALL resolve each operand at acceptance with this priority: RF value if !rob_tag_valid[i]; else the lowest-index channel j with byp_en[j] && byp_tag[j]==rob_tag[i]; else rob_data[i] if rob_data_valid[i]; else the operand is pending.
REQ-019 SHALL register the resolved values, the pending flags and the tags on acceptance.
REQ-020 SHALL go to READY after acceptance if no operand is pending, and to WAIT otherwise.
REQ-021 SHALL, in WAIT, snoop only the bypass buses each cycle for each pending operand, using the REQ-018 bypass priority.
REQ-022 SHALL capture a value in the cycle it matches and clear the pending flag.
REQ-023 SHALL ignore later matches on operands that are no longer pending.
REQ-024 SHALL go from WAIT to READY in the cycle after the last pending operand is captured; operands captured in the same cycle all count.
REQ-025 SHALL assert out_valid only in READY, with out_data being the registered operands.
REQ-026 SHALL hold out_valid and out_data stable until out_ready is high.
REQ-027 SHALL, on out_valid && out_ready, go to IDLE, or load the new request if one is accepted in that same cycle (back-to-back, no bubble).
REQ-028 SHALL give a latency of 1 cycle from acceptance to out_valid when all operands resolve at acceptance.
REQ-029 SHALL treat ROB tags as opaque; tag equality compares all ROB_ENTRY_WIDTH bits, with no wrap-around logic.
REQ-030 SHALL, on flush, go to IDLE the next cycle, drop any held instruction and accept nothing in that cycle.
REQ-031 SHALL give flush priority over both handshakes.

Reset
REQ-032 SHALL, on reset, set state to IDLE and clear out_valid, busy, the pending flags and out_data (all zero).
REQ-033 SHALL give reset priority over flush and the handshakes, and SHALL abandon any in-flight operation without producing output.
REQ-034 SHALL drive in_ready low during the reset cycle.

Verification
REQ-035 Bench SHALL cover: rob_tag_valid=00, rf_data={5,7}, out_ready=1 -> out_valid next cycle with out_data={5,7}.
REQ-036 Bench SHALL cover: op0 tag 3 with byp_en[2] and byp_en[4] both high, tag 3, data A and B -> op0 = A (channel 2 wins); op1 taken from rob_data=9.
REQ-037 Bench SHALL cover: op0 tag 5 with no match at acceptance -> busy=1; byp tag 5, data 0x11 three cycles later -> out_valid the next cycle with op0=0x11; a later tag-5 broadcast leaves it unchanged.
REQ-038 Bench SHALL cover: READY with out_ready=0 for 4 cycles -> out_data stable; then out_ready=1 with in_valid=1 -> the new request is accepted the same cycle with no idle cycle.
REQ-039 Bench SHALL cover: flush while in WAIT -> IDLE next cycle with out_valid=0; a matching bypass in the flush cycle is not captured.
REQ-040 Bench SHALL cover: reset asserted in READY -> out_valid=0, busy=0 and out_data=0 the next cycle, with in_ready=0 during the reset cycle.
